// File: rtl/weight_stream_ctrl.sv
// Streams a weight ROM into a FIFO, NUM_PASSES times per start, through a
// 2-entry skid buffer that absorbs the one-cycle ROM read latency.
module weight_stream_ctrl #(
    parameter int unsigned MEM_SIZE   = 64,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_PASSES = 1,
    localparam int unsigned AW = (MEM_SIZE > 1) ? $clog2(MEM_SIZE) : 1
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  ap_start,
    output logic                  ap_done,
    output logic                  ap_idle,
    output logic [AW-1:0]         rom_address,
    output logic                  rom_ce,
    input  logic [DATA_WIDTH-1:0] rom_q,
    output logic [DATA_WIDTH-1:0] output_V_din,
    input  logic                  output_V_full_n,
    output logic                  output_V_write
);

    localparam int unsigned PW = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
    localparam logic [AW-1:0] AddrMax = AW'(MEM_SIZE - 1);
    localparam logic [PW-1:0] PassMax = PW'(NUM_PASSES - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e                state_q, state_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [PW-1:0]         pass_q, pass_d;
    logic                  in_flight_q;
    logic [1:0]            occ_q;
    logic [DATA_WIDTH-1:0] head_q, tail_q;

    logic       push, pop, issue, last_read;
    logic [2:0] level;

    always_comb begin
        push      = in_flight_q;
        pop       = (occ_q != 2'd0) && output_V_full_n;
        // Committed words after this cycle's pop; keeps the buffer from overflowing.
        level     = {1'b0, occ_q} + {2'b00, in_flight_q} - {2'b00, pop};
        issue     = (state_q == StRun) && (level < 3'd2);
        last_read = (addr_q == AddrMax) && (pass_q == PassMax);

        state_d = state_q;
        addr_d  = addr_q;
        pass_d  = pass_q;
        case (state_q)
            StIdle: begin
                if (ap_start) begin
                    state_d = StRun;
                    addr_d  = '0;
                    pass_d  = '0;
                end
            end
            StRun: begin
                if (issue) begin
                    if (last_read) begin
                        state_d = StDrain;
                    end else if (addr_q == AddrMax) begin
                        addr_d = '0;
                        pass_d = pass_q + PW'(1);
                    end else begin
                        addr_d = addr_q + AW'(1);
                    end
                end
            end
            StDrain: begin
                if (occ_q == 2'd0 && !in_flight_q) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q <= StIdle;
            addr_q  <= '0;
            pass_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            pass_q  <= pass_d;
        end
    end

    // Skid buffer: head_q always holds the oldest entry and drives the FIFO directly.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            in_flight_q <= 1'b0;
            occ_q       <= 2'd0;
            head_q      <= '0;
            tail_q      <= '0;
        end else begin
            in_flight_q <= issue;
            case ({push, pop})
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        head_q <= rom_q;
                    end else begin
                        tail_q <= rom_q;
                    end
                    occ_q <= occ_q + 2'd1;
                end
                2'b01: begin
                    head_q <= tail_q;
                    occ_q  <= occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        head_q <= rom_q;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= rom_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ap_idle        = (state_q == StIdle);
    assign ap_done        = (state_q == StDone);
    assign rom_ce         = issue;
    assign rom_address    = addr_q;
    assign output_V_write = pop;
    assign output_V_din   = head_q;

endmodule

// File: doc/weight_stream_ctrl.md
WEIGHT_STREAM_CTRL -- requirements
Module: weight_stream_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: ap_clk clocks all state, and ap_rst is sampled on the ap_clk rising edge.
REQ-002 Parameter MEM_SIZE, default 64: number of coefficients in the weight ROM (>=1).
REQ-003 Parameter DATA_WIDTH, default 16: coefficient width in bits.
REQ-004 Parameter NUM_PASSES, default 1: times the full ROM is streamed per start (>=1).
REQ-005 AW = ceil(log2(MEM_SIZE)), minimum 1.
REQ-006 ap_clk  in  1  clock.
REQ-007 ap_rst  in  1  synchronous active-high reset.
REQ-008 ap_start  in  1  run request, level-sampled in IDLE only.
REQ-009 ap_done  out  1  single-cycle pulse, run complete.
REQ-010 ap_idle  out  1  high while in IDLE.
REQ-011 rom_address  out  AW  ROM read address.
REQ-012 rom_ce  out  1  ROM read enable.
REQ-013 rom_q  in  DATA_WIDTH  ROM data, valid the cycle after rom_ce (1-cycle synchronous ROM).
REQ-014 output_V_din  out  DATA_WIDTH  coefficient to the FIFO.
REQ-015 output_V_full_n  in  1  FIFO not full.
REQ-016 output_V_write  out  1  FIFO write strobe.

Function
REQ-017 States SHALL be IDLE, RUN, DRAIN, DONE; IDLE->RUN on ap_start=1, RUN->DRAIN when the last read is issued, DRAIN->DONE when buffer empty and no read in flight, DONE->IDLE unconditionally.
REQ-018 ap_idle SHALL be 1 exactly in IDLE; ap_done SHALL be 1 exactly in DONE (one cycle).
REQ-019 On IDLE->RUN the address counter and pass counter SHALL load 0.
REQ-020 An internal 2-entry FIFO skid buffer SHALL capture rom_q one cycle after each issued read; in-flight reads SHALL be counted.
REQ-021 pop = output_V_write; output_V_write SHALL be (buffer occupancy>0) AND output_V_full_n, and SHALL never be 1 while output_V_full_n=0.
REQ-022 output_V_din SHALL be the buffer head entry, registered.
REQ-023 In RUN, rom_ce SHALL be 1 iff (occupancy + in_flight - pop) < 2, giving 1 word/cycle sustained when full_n stays 1.
REQ-024 On each issued read the address SHALL increment; at MEM_SIZE-1 it SHALL wrap to 0 and the pass counter SHALL increment.
REQ-025 The read issued at address MEM_SIZE-1 with pass NUM_PASSES-1 SHALL be the last one; rom_ce SHALL be 0 outside RUN.
REQ-026 Exactly MEM_SIZE*NUM_PASSES words SHALL be written per run, in address order, pass after pass, with no loss or duplication under any full_n pattern.
REQ-027 Latency: ap_start=1 in IDLE at cycle 0 gives rom_ce=1 at cycle 1 and the earliest output_V_write=1 at cycle 3.
REQ-028 ap_start SHALL be ignored in RUN, DRAIN and DONE; if held high it SHALL restart a run on the IDLE cycle after DONE.
REQ-029 Buffer push and pop in the same cycle SHALL keep occupancy unchanged; push into a full buffer SHALL be impossible by REQ-023.

Reset
REQ-030 While ap_rst=1: state=IDLE, counters=0, buffer emptied, in-flight reads discarded, rom_address=0, rom_ce=0, output_V_write=0, output_V_din=0, ap_done=0, ap_idle=1.
REQ-031 Reset mid-run SHALL abandon the run; any rom_q arriving the cycle after reset SHALL be dropped; the next start SHALL begin at address 0, pass 0.

Verification
REQ-032 MEM_SIZE=4, NUM_PASSES=2, ROM {0x11,0x22,0x33,0x44}, full_n=1, one-cycle start at cycle 0 -> writes cycles 3..10 with data 11,22,33,44,11,22,33,44; ap_done=1 in exactly one cycle after cycle 10.
REQ-033 Same setup, full_n=0 for cycles 5..14 -> no write in 5..14, rom_ce=0 once occupancy+in_flight=2, the 8-word sequence intact and in order, ap_done after the last write.
REQ-034 Random full_n (50%) over 1000 runs -> scoreboard: counts equal, order correct, no write with full_n=0.
REQ-035 ap_rst pulsed after the 5th write -> next cycle all REQ-030 values hold; a new start yields 0x11 first.
REQ-036 MEM_SIZE=1, NUM_PASSES=1, ROM {0xAB} -> single write 0xAB at cycle 3, rom_address stays 0, done follows.
REQ-037 ap_start held high continuously -> back-to-back runs separated by exactly one IDLE cycle; no run starts in DONE.
